// File: rtl/lisa_rx_fifo_if.sv
// Bundle of the upstream receiver handshake and the consumer-side FIFO port.
// Handshake: rx_rd rises once per captured byte and stays high until rx_avail is seen low.
interface lisa_rx_fifo_if;
    logic [7:0] rx_d;
    logic       rx_avail;
    logic       rx_rd;
    logic       pop;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       stall;
    logic       clr_stall;
    logic       dbg_state;

    modport slave (
        input  rx_d, rx_avail, pop, clr_stall,
        output rx_rd, dout, empty, full, count, stall, dbg_state
    );

    modport master (
        output rx_d, rx_avail, pop, clr_stall,
        input  rx_rd, dout, empty, full, count, stall, dbg_state
    );
endinterface

// File: rtl/lisa_rx_fifo.sv
// Receive FIFO that pulls bytes from an 8N1 receiver with a level/strobe handshake
// and presents them show-ahead to a consumer.
module lisa_rx_fifo #(
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    lisa_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t          state, state_nx;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [4:0]      count;
    logic            capture, set_stall, do_pop;
    logic            full, empty;

    assign full   = (count == 5'(DEPTH));
    assign empty  = (count == 5'd0);
    assign do_pop = bus.pop && !empty;

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        set_stall = 1'b0;
        case (state)
            IDLE: begin
                if (bus.rx_avail) begin
                    if (!full) begin
                        capture  = 1'b1;
                        state_nx = ACK;
                    end else begin
                        set_stall = 1'b1;
                    end
                end
            end
            ACK: begin
                // rx_avail still high here is the same byte, not a new one
                if (!bus.rx_avail) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            if (capture) begin
                mem[wr_ptr] <= bus.rx_d;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({capture, do_pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

    // Set has priority over the synchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                bus.stall <= 1'b0;
        else if (set_stall)     bus.stall <= 1'b1;
        else if (bus.clr_stall) bus.stall <= 1'b0;
    end

    // rx_rd comes straight from the state register, so reset drops it immediately
    assign bus.rx_rd     = (state == ACK);
    assign bus.dout      = mem[rd_ptr];
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.count     = count;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_lisa_rx_fifo.sv
// Self-checking bench for lisa_rx_fifo (DEPTH=4): directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_lisa_rx_fifo;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lisa_rx_fifo_if bus ();

  lisa_rx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  logic [7:0] exp_q[$];
  bit         hs_open;
  bit         stall_m;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%02h expected=0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic a, input logic [7:0] d, input logic p, input logic c);
    bit was_full, was_empty, pop_ok, cap;
    was_full  = (exp_q.size() == DEPTH);
    was_empty = (exp_q.size() == 0);
    pop_ok    = p && !was_empty;
    cap       = !hs_open && a && !was_full;
    if (!hs_open && a && was_full) stall_m = 1'b1;
    else if (c)                    stall_m = 1'b0;
    if (hs_open && !a) hs_open = 1'b0;
    if (cap) hs_open = 1'b1;
    if (pop_ok) void'(exp_q.pop_front());
    if (cap) exp_q.push_back(d);
  endtask

  task automatic compare_all();
    check("count", {3'b000, bus.count}, 8'(exp_q.size()));
    check("empty", {7'd0, bus.empty}, {7'd0, exp_q.size() == 0});
    check("full",  {7'd0, bus.full},  {7'd0, exp_q.size() == DEPTH});
    check("rx_rd", {7'd0, bus.rx_rd}, {7'd0, hs_open});
    check("stall", {7'd0, bus.stall}, {7'd0, stall_m});
    if (exp_q.size() > 0) check("dout", bus.dout, exp_q[0]);
  endtask

  task automatic cycle(input logic a, input logic [7:0] d, input logic p, input logic c);
    @(negedge clk);
    bus.rx_avail  = a;
    bus.rx_d      = d;
    bus.pop       = p;
    bus.clr_stall = c;
    @(posedge clk);
    model_step(a, d, p, c);
    #1;
    compare_all();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_rx_rd"}, {7'd0, bus.rx_rd}, 8'h00);
    check({tag, "_count"}, {3'b000, bus.count}, 8'h00);
    check({tag, "_empty"}, {7'd0, bus.empty}, 8'h01);
    check({tag, "_full"},  {7'd0, bus.full},  8'h00);
    check({tag, "_dout"},  bus.dout, 8'h00);
    check({tag, "_stall"}, {7'd0, bus.stall}, 8'h00);
  endtask

  // assert rst between clock edges, check asynchronously, release on a falling edge
  task automatic do_reset(input string tag);
    #2 rst = 1'b1;
    #1 reset_checks(tag);
    bus.rx_avail  = 1'b0;
    bus.rx_d      = 8'h00;
    bus.pop       = 1'b0;
    bus.clr_stall = 1'b0;
    exp_q.delete();
    hs_open = 1'b0;
    stall_m = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.rx_avail  = 1'b0;
    bus.rx_d      = 8'h00;
    bus.pop       = 1'b0;
    bus.clr_stall = 1'b0;
    hs_open = 1'b0;
    stall_m = 1'b0;
    do_reset("rst_init");

    // single byte, then pop
    cycle(1, 8'hA5, 0, 0);
    cycle(1, 8'hA5, 0, 0);
    cycle(0, 8'h00, 0, 0);
    check("single_dout", bus.dout, 8'hA5);
    check("single_count", {3'b000, bus.count}, 8'h01);
    cycle(0, 8'h00, 1, 0);
    check("single_empty", {7'd0, bus.empty}, 8'h01);

    // fill and stall
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 8'(i * 8'h11), 0, 0);
      cycle(0, 8'h00, 0, 0);
    end
    repeat (3) cycle(1, 8'h55, 0, 0);
    check("fill_full", {7'd0, bus.full}, 8'h01);
    check("fill_rx_rd", {7'd0, bus.rx_rd}, 8'h00);
    check("fill_stall", {7'd0, bus.stall}, 8'h01);
    cycle(1, 8'h55, 0, 1);
    check("clr_full_stall", {7'd0, bus.stall}, 8'h01);
    cycle(1, 8'h55, 1, 0);
    check("pop_full_count", {3'b000, bus.count}, 8'h03);
    cycle(1, 8'h55, 0, 0);
    check("fill_dout", bus.dout, 8'h22);
    check("fill_count", {3'b000, bus.count}, 8'h04);
    check("fill_ack", {7'd0, bus.rx_rd}, 8'h01);

    // reset while acknowledging, stall set
    do_reset("rst_ack");
    cycle(1, 8'h3C, 0, 0);
    check("post_rst_capture", {3'b000, bus.count}, 8'h01);
    cycle(0, 8'h00, 0, 0);

    // clear stall while not full
    for (int i = 0; i < 3; i++) begin
      cycle(1, 8'(8'h60 + i), 0, 0);
      cycle(0, 8'h00, 0, 0);
    end
    cycle(1, 8'h70, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 1, 0);
    check("pre_clr_stall", {7'd0, bus.stall}, 8'h01);
    cycle(0, 8'h00, 0, 1);
    check("clr_stall", {7'd0, bus.stall}, 8'h00);
    while (exp_q.size() > 0) cycle(0, 8'h00, 1, 0);

    // wrap-around
    for (int i = 0; i < 10; i++) begin
      cycle(1, 8'(i), 0, 0);
      check("wrap_dout", bus.dout, 8'(i));
      cycle(0, 8'h00, 1, 0);
    end
    check("wrap_empty", {7'd0, bus.empty}, 8'h01);

    // simultaneous capture and pop
    cycle(1, 8'hB1, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'hB2, 0, 0);
    cycle(0, 8'h00, 0, 0);
    cycle(1, 8'hB3, 1, 0);
    check("simul_count", {3'b000, bus.count}, 8'h02);
    check("simul_dout", bus.dout, 8'hB2);
    cycle(0, 8'h00, 1, 0);
    cycle(0, 8'h00, 1, 0);
    cycle(1, 8'hC4, 1, 0);
    check("simul_empty_count", {3'b000, bus.count}, 8'h01);
    check("simul_empty_dout", bus.dout, 8'hC4);
    cycle(0, 8'h00, 1, 0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(logic'($urandom_range(0, 99) < 60), 8'($urandom),
            logic'($urandom_range(0, 99) < 40), logic'($urandom_range(0, 99) < 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
